fetch: RTL and testbench

FETCH -- requirements
Module: fetch

---
 rtl/fetch.sv | 158 +++++++++++++++
 tb/tb_fetch.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// Instruction fetch stage: one outstanding request, single-entry output hold.
// Optional FETCH_MISALIGN_TRAP_EN: a misaligned redirect traps and halts fetch.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        output_valid,
  input  logic        output_ready,
  output logic [31:0] instr,
  output logic [31:0] pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        trap
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN,
    HOLD
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_fetch_pc;
  logic [31:0] w_fetch_pc_nxt;
  logic [31:0] r_target;
  logic [31:0] w_target_nxt;
  logic [31:0] r_instr;
  logic [31:0] w_instr_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic        r_ovalid;
  logic        w_ovalid_nxt;
  logic [31:0] w_tgt;
  logic        w_redir;
  logic        w_bad;
  logic        w_halt;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_trap;
  logic w_trap_nxt;

  assign w_tgt   = redirect_target;
  assign w_bad   = redirect_valid && (redirect_target[1:0] != 2'b00);
  assign w_redir = redirect_valid && !w_bad;
  assign w_halt  = r_trap;
  assign trap    = r_trap;
`else
  // Low target bits are dropped so every fetch stays word aligned
  assign w_tgt   = redirect_target & 32'hFFFF_FFFC;
  assign w_bad   = 1'b0;
  assign w_redir = redirect_valid;
  assign w_halt  = 1'b0;
`endif

  assign mem_valid    = (r_state == REQ) || (r_state == DRAIN);
  assign mem_addr     = r_fetch_pc;
  assign output_valid = r_ovalid;
  assign instr        = r_instr;
  assign pc           = r_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_target   <= 32'h0;
      r_instr    <= 32'h0;
      r_pc       <= 32'h0;
      r_ovalid   <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      r_trap     <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_target   <= w_target_nxt;
      r_instr    <= w_instr_nxt;
      r_pc       <= w_pc_nxt;
      r_ovalid   <= w_ovalid_nxt;
`ifdef FETCH_MISALIGN_TRAP_EN
      r_trap     <= w_trap_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_target_nxt   = r_target;
    w_instr_nxt    = r_instr;
    w_pc_nxt       = r_pc;
    w_ovalid_nxt   = r_ovalid;
`ifdef FETCH_MISALIGN_TRAP_EN
    w_trap_nxt     = r_trap;
`endif
    if (w_bad) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      w_trap_nxt   = 1'b1;
`endif
      w_state_nxt  = IDLE;
      w_ovalid_nxt = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (!w_halt) begin
            w_state_nxt = REQ;
            if (w_redir) w_fetch_pc_nxt = w_tgt;
          end
        end
        REQ: begin
          if (w_redir) begin
            if (mem_ready) begin
              w_fetch_pc_nxt = w_tgt;
            end else begin
              w_target_nxt = w_tgt;
              w_state_nxt  = DRAIN;
            end
          end else if (mem_ready) begin
            w_instr_nxt  = mem_rdata;
            w_pc_nxt     = r_fetch_pc;
            w_ovalid_nxt = 1'b1;
            w_state_nxt  = HOLD;
          end
        end
        DRAIN: begin
          // The bus request stays up; only the resume address changes
          if (w_redir) w_target_nxt = w_tgt;
          if (mem_ready) begin
            w_fetch_pc_nxt = w_redir ? w_tgt : r_target;
            w_state_nxt    = REQ;
          end
        end
        HOLD: begin
          if (w_redir) begin
            w_ovalid_nxt   = 1'b0;
            w_fetch_pc_nxt = w_tgt;
            w_state_nxt    = REQ;
          end else if (output_ready) begin
            w_ovalid_nxt   = 1'b0;
            w_fetch_pc_nxt = r_pc + 32'd4;
            w_state_nxt    = REQ;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Randomized bench for fetch against a transaction-level model.
// Build with FETCH_MISALIGN_TRAP_EN to cover the trap port.
module tb_fetch;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        output_valid;
  logic        output_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        trap;
`endif

  int n_chk = 0;
  int n_fail = 0;

  // model state: in-flight request, drop flag, held output
  logic        m_busy, m_drop, m_ov, m_trap;
  logic [31:0] m_addr, m_pend, m_pc, m_instr, m_nxt;

  logic        q_ov[$];
  logic [31:0] q_addr[$];

  always #5 clk = ~clk;

  fetch #(.RESET_PC(RPC)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .output_valid   (output_valid),
    .output_ready   (output_ready),
    .instr          (instr),
    .pc             (pc),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .trap           (trap)
`endif
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign mem_rdata = memf(mem_addr);

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_drop = 0; m_ov = 0; m_trap = 0;
    m_addr = 0; m_pend = 0; m_pc = 0; m_instr = 0;
    m_nxt = RPC;
  endtask

  task automatic model_step(input logic rv, input logic [31:0] tgt,
                            input logic mr, input logic ordy);
    logic [31:0] t;
`ifdef FETCH_MISALIGN_TRAP_EN
    t = tgt;
    if (m_trap) return;
    if (rv && tgt[1:0] != 2'b00) begin
      m_trap = 1; m_busy = 0; m_ov = 0;
      return;
    end
`else
    t = {tgt[31:2], 2'b00};
`endif
    if (!m_busy && !m_ov) begin
      m_busy = 1; m_drop = 0;
      m_addr = rv ? t : m_nxt;
    end else if (m_busy) begin
      if (mr) begin
        if (m_drop || rv) begin
          m_addr = rv ? t : m_pend;
          m_drop = 0;
        end else begin
          m_busy = 0; m_ov = 1;
          m_pc = m_addr; m_instr = memf(m_addr);
        end
      end else if (rv) begin
        m_drop = 1; m_pend = t;
      end
    end else begin
      if (rv) begin
        m_ov = 0; m_busy = 1; m_addr = t;
      end else if (ordy) begin
        m_ov = 0; m_busy = 1; m_addr = m_pc + 32'd4;
      end
    end
  endtask

  task automatic compare();
    check("mem_valid", {31'b0, mem_valid}, {31'b0, m_busy});
    if (m_busy) check("mem_addr", mem_addr, m_addr);
    check("output_valid", {31'b0, output_valid}, {31'b0, m_ov});
    check("instr", instr, m_instr);
    check("pc", pc, m_pc);
    check("ov_and_mv", {31'b0, output_valid & mem_valid}, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("trap", {31'b0, trap}, {31'b0, m_trap});
`endif
  endtask

  task automatic cyc(input logic rv, input logic [31:0] tgt,
                     input logic mr, input logic ordy);
    @(negedge clk);
    compare();
    if (mem_valid) q_addr.push_back(mem_addr);
    q_ov.push_back(output_valid);
    reset = 0;
    redirect_valid = rv;
    redirect_target = tgt;
    mem_ready = mr;
    output_ready = ordy;
    @(posedge clk);
    model_step(rv, tgt, mr, ordy);
  endtask

  task automatic do_reset(input logic mr);
    @(negedge clk);
    reset = 1;
    redirect_valid = 0;
    mem_ready = mr;
    output_ready = 0;
    @(posedge clk);
    model_reset();
    #1;
    check("rst_mem_valid", {31'b0, mem_valid}, 32'h0);
    check("rst_output_valid", {31'b0, output_valid}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc", pc, 32'h0);
  endtask

  initial begin
    int ovs;
    logic [31:0] t;
    model_reset();
    do_reset(0);

    // streaming at full rate
    q_addr.delete();
    q_ov.delete();
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 1);
    check("stream_a0", q_addr[0], 32'h100);
    check("stream_a1", q_addr[1], 32'h104);
    check("stream_a2", q_addr[2], 32'h108);
    ovs = 0;
    foreach (q_ov[i]) ovs += int'(q_ov[i]);
    check("stream_ov_cnt", ovs, 3);
    check("stream_ov2", {31'b0, q_ov[2]}, 32'h1);
    check("stream_ov4", {31'b0, q_ov[4]}, 32'h1);

    // hold under backpressure
    do_reset(0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 0);
      #1;
      check("hold_instr", instr, 32'hDEAD_BEEF);
      check("hold_pc", pc, 32'h100);
      check("hold_mv", {31'b0, mem_valid}, 32'h0);
    end
    cyc(0, 0, 0, 1);

    // redirect while request outstanding
    cyc(1, 32'h200, 0, 0);
    #1 check("drain_addr", mem_addr, 32'h104);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 0);
      #1 check("drain_addr", mem_addr, 32'h104);
    end
    cyc(0, 0, 1, 0);
    #1;
    check("redir_addr", mem_addr, 32'h200);
    check("redir_drop", {31'b0, output_valid}, 32'h0);

    // redirect beats acceptance in HOLD
    cyc(0, 0, 1, 0);
    #1 check("hold_ov", {31'b0, output_valid}, 32'h1);
    cyc(1, 32'h300, 0, 1);
    #1;
    check("hold_redir_ov", {31'b0, output_valid}, 32'h0);
    check("hold_redir_addr", mem_addr, 32'h300);

    // pc wrap
    cyc(0, 0, 1, 0);
    cyc(1, 32'hFFFF_FFFC, 0, 1);
    cyc(0, 0, 1, 0);
    #1 check("wrap_pc", pc, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 1);
    #1 check("wrap_addr", mem_addr, 32'h0);

    cyc(0, 0, 1, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
    cyc(1, 32'h202, 0, 0);
    #1;
    check("trap_set", {31'b0, trap}, 32'h1);
    check("trap_mv", {31'b0, mem_valid}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 32'h400, 1, 1);
      #1 check("trap_stay_mv", {31'b0, mem_valid}, 32'h0);
    end
    do_reset(0);
    #1 check("trap_clr", {31'b0, trap}, 32'h0);
    cyc(0, 0, 0, 0);
`else
    cyc(1, 32'h402, 0, 0);
    #1 check("mask_addr", mem_addr, 32'h400);
`endif

    // reset mid-request, stale ready ignored
    do_reset(1);
    cyc(0, 0, 1, 1);
    #1;
    check("post_rst_mv", {31'b0, mem_valid}, 32'h1);
    check("post_rst_addr", mem_addr, RPC);
    check("post_rst_ov", {31'b0, output_valid}, 32'h0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(1'($urandom_range(0, 1)));
      end else begin
        t = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
        if ($urandom_range(0, 99) != 0) t[1:0] = 2'b00;
`endif
        cyc($urandom_range(0, 7) == 0, t,
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      end
    end
    cyc(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
